count_hex_display: RTL and testbench
====================================

// Module: count_hex_display
// PURPOSE
//  Downstream consumer of the 4-bit binary up-counter output.
//  Samples the counter value, detects wrap-around (MAX->0), and keeps a mod-16 wrap count.
//  Time-multiplexes both values onto a 2-digit seven-segment display (digit0 = count, digit1 = wraps).
//  Sits between the counter and the board display pins.
// PARAMETERS
//  CNT_W        4      width of sampled count and of wrap counter; MAX = 2**CNT_W-1
//  REFRESH_DIV  50000  clk cycles per digit slot (>=2); benches override to 4
//  SEG_ACT_LOW  1      1: seg and an active-low (common anode); 0: active-high
// PORTS
//  clk         in   1      system clock, all flops rising-edge
//  reset       in   1      synchronous, active-high
//  count       in   CNT_W  upstream counter value, sampled every cycle
//  seg         out  7      segments {g,f,e,d,c,b,a}, registered
//  an          out  2      digit enables, registered
//  wrap_pulse  out  1      one-cycle pulse per detected wrap, registered
// BEHAVIOUR
//  Reset (reset high at edge): cnt_q=0, prev_q=0, wrap_cnt=0, refresh=0, digit_sel=0,
//   wrap_pulse=0, seg=blank (all off), an=both off. Applies mid-operation, no partial state kept.
//  Sampling: each edge cnt_q<=count, prev_q<=cnt_q.
//  Wrap detect: wrap_pulse<=(prev_q==MAX && cnt_q==0). Asserts on the 2nd edge after count
//   first shows 0 following MAX; high exactly 1 cycle. wrap_cnt increments on the same edge, mod 2**CNT_W.
//  Only the exact MAX->0 transition counts. Other jumps, e.g. 7->0 upstream reset, 5->9, are not wraps.
//   A 15->0 caused by an upstream reset is indistinguishable from a wrap and counts as one.
//  No false wrap after reset: prev_q=0.
//  Refresh: refresh counts 0..REFRESH_DIV-1. At REFRESH_DIV-1 it returns to 0 and digit_sel toggles.
//  Display reg, every edge out of reset:
//   seg<=decode(digit_sel ? wrap_cnt : cnt_q)
//   an<=digit_sel ? 2'b10 : 2'b01 (active-low form; invert when SEG_ACT_LOW=0)
//  Latency: count change -> seg update = 2 edges while digit0 is selected.
//  After reset: first edge shows digit0 (an=2'b10 low form = digit0 on).
//  Decode (active-high gfedcba):
//   0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
//   SEG_ACT_LOW inverts. Blank = all segments off.
//  Simultaneous: a wrap and a digit toggle on the same edge are both applied; the displayed digit
//   takes the pre-increment wrap_cnt and updates next edge.
// STRUCTURE
//  Shared package count_disp_pkg: SEG_BLANK, 16-entry hex->segment constant table, DIGIT_CNT=2.
//  One sub-module: hex_to_seg7 (pure combinational 4-bit -> 7-bit decoder, SEG_ACT_LOW param).
//  Top holds the sampling regs, wrap detector, refresh divider, mux and output regs.
// TESTING (REFRESH_DIV=4, SEG_ACT_LOW=1)
//  1 Hold reset 3 cycles -> seg=7'h7F, an=2'b11, wrap_pulse=0. After release, an=2'b10 within 1 cycle.
//  2 count=3 steady, digit0 slot -> seg=7'h30; count=0 -> seg=7'h40 after 2 edges.
//  3 Sweep 0..15 then 0 -> wrap_pulse high exactly 1 cycle, 2 edges after 0. Digit1 then shows 1 (seg=7'h79).
//  4 Drive 16 full wraps -> 16 pulses; wrap_cnt returns to 0 (digit1 seg=7'h40).
//  5 Jumps 7->0 and 5->9 -> no wrap_pulse; wrap_cnt unchanged.
//  6 Assert reset one cycle mid-sweep at count=15, then drive 0 -> no wrap_pulse; all outputs at reset values for that edge.
//  All: an toggles every 4 cycles; never both digits on; assert 1-cycle wrap_pulse width.

Source files
------------

// File: rtl/count_disp_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | count_disp_pkg : shared constants for the count/wrap hex display    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package count_disp_pkg;

  localparam int DIGIT_CNT = 2;

  // Segment patterns are held active-high, {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [15:0][6:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef enum logic {
    DIGIT0 = 1'b0,
    DIGIT1 = 1'b1
  } digit_e;

  function automatic logic [6:0] seg_polarity(input logic [6:0] seg_hi, input bit act_low);
    return act_low ? ~seg_hi : seg_hi;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hex_to_seg7.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hex_to_seg7 : combinational 4-bit hex to seven-segment decoder      |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module hex_to_seg7
  import count_disp_pkg::*;
#(
  parameter int SEG_ACT_LOW = 1
) (
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  assign seg_o = seg_polarity(HEX_SEG[hex_i], SEG_ACT_LOW != 0);

endmodule
`default_nettype wire

// File: rtl/count_hex_display.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | count_hex_display : samples an up-counter, counts its wraps and     |
// | multiplexes both values onto a 2-digit seven-segment display.      |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module count_hex_display
  import count_disp_pkg::*;
#(
  parameter int CNT_W       = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int SEG_ACT_LOW = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CNT_W-1:0]     count,
  output logic [6:0]           seg,
  output logic [DIGIT_CNT-1:0] an,
  output logic                 wrap_pulse
);

  localparam int                   REF_W    = $clog2(REFRESH_DIV);
  localparam logic [REF_W-1:0]     REF_LAST = REF_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0]     CNT_MAX  = '1;
  localparam bit                   ACT_LOW  = (SEG_ACT_LOW != 0);
  localparam logic [DIGIT_CNT-1:0] AN_OFF   = ACT_LOW ? 2'b11 : 2'b00;
  localparam logic [DIGIT_CNT-1:0] AN_DIG0  = ACT_LOW ? 2'b10 : 2'b01;
  localparam logic [DIGIT_CNT-1:0] AN_DIG1  = ACT_LOW ? 2'b01 : 2'b10;
  localparam logic [6:0]           SEG_OFF  = seg_polarity(SEG_BLANK, ACT_LOW);

  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     prev_q, prev_d;
  logic [CNT_W-1:0]     wrap_cnt_q, wrap_cnt_d;
  logic [REF_W-1:0]     refresh_q, refresh_d;
  digit_e               digit_sel_q, digit_sel_d;
  logic                 wrap_pulse_q, wrap_pulse_d;
  logic [6:0]           seg_q, seg_d;
  logic [DIGIT_CNT-1:0] an_q, an_d;

  logic                 wrap_det;
  logic [CNT_W-1:0]     mux_val;
  logic [6:0]           dec_seg;

  // Only the low nibble of the selected value is shown on a digit.
  assign mux_val = (digit_sel_q == DIGIT1) ? wrap_cnt_q : cnt_q;

  hex_to_seg7 #(
    .SEG_ACT_LOW(SEG_ACT_LOW)
  ) u_dec (
    .hex_i(4'(mux_val)),
    .seg_o(dec_seg)
  );

  always_comb begin
    cnt_d        = count;
    prev_d       = cnt_q;
    wrap_det     = (prev_q == CNT_MAX) && (cnt_q == '0);
    wrap_pulse_d = wrap_det;
    wrap_cnt_d   = wrap_det ? wrap_cnt_q + CNT_W'(1) : wrap_cnt_q;
    refresh_d    = refresh_q + REF_W'(1);
    digit_sel_d  = digit_sel_q;
    if (refresh_q == REF_LAST) begin
      refresh_d   = '0;
      digit_sel_d = (digit_sel_q == DIGIT0) ? DIGIT1 : DIGIT0;
    end
    // Display uses the current wrap count, so a same-edge wrap shows one edge later.
    seg_d = dec_seg;
    an_d  = (digit_sel_q == DIGIT1) ? AN_DIG1 : AN_DIG0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= '0;
      prev_q       <= '0;
      wrap_cnt_q   <= '0;
      refresh_q    <= '0;
      digit_sel_q  <= DIGIT0;
      wrap_pulse_q <= 1'b0;
      seg_q        <= SEG_OFF;
      an_q         <= AN_OFF;
    end else begin
      cnt_q        <= cnt_d;
      prev_q       <= prev_d;
      wrap_cnt_q   <= wrap_cnt_d;
      refresh_q    <= refresh_d;
      digit_sel_q  <= digit_sel_d;
      wrap_pulse_q <= wrap_pulse_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign wrap_pulse = wrap_pulse_q;

endmodule
`default_nettype wire

// File: tb/tb_count_hex_display.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_count_hex_display : directed bench, REFRESH_DIV=4, active-low    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_count_hex_display;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] count = 4'd0;
  logic [6:0] seg;
  logic [1:0] an;
  logic       wrap_pulse;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  int         pulse_cnt   = 0;
  int         width_viol  = 0;
  int         both_on     = 0;
  int         period_viol = 0;
  int         toggles     = 0;
  int         run         = 0;
  logic [1:0] prev_an     = 2'b11;
  logic       prev_wp     = 1'b0;

  count_hex_display #(
    .CNT_W(4),
    .REFRESH_DIV(4),
    .SEG_ACT_LOW(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .count(count),
    .seg(seg),
    .an(an),
    .wrap_pulse(wrap_pulse)
  );

  always #5 clk = ~clk;

  // Free-running observer on the falling edge: pulse count, pulse width, digit overlap, slot length.
  initial begin
    forever begin
      @(negedge clk);
      if (!$isunknown({an, wrap_pulse})) begin
        if (wrap_pulse) begin
          pulse_cnt++;
          if (prev_wp) width_viol++;
        end
        prev_wp = wrap_pulse;
        if (an == 2'b00) both_on++;
        if (an == 2'b11) begin
          prev_an = 2'b11;
          run     = 0;
        end else if (an == prev_an) begin
          run++;
        end else begin
          if (prev_an != 2'b11) begin
            toggles++;
            if (run != 4) period_viol++;
          end
          prev_an = an;
          run     = 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b1;
    repeat (n) tick();
    reset = 1'b0;
    cyc   = 0;
  endtask

  // Advance until the next edge is the first edge of digit d's slot.
  task automatic align(input int d);
    while (!((cyc % 4) == 0 && ((cyc / 4) % 2) == d)) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    count = 4'd0;
    repeat (3) tick();
    n_vec++; if (seg !== 7'h7F) begin n_err++; $display("FAIL reset_seg: got %h want %h", seg, 7'h7F); end
    n_vec++; if (an !== 2'b11) begin n_err++; $display("FAIL reset_an: got %b want %b", an, 2'b11); end
    n_vec++; if (wrap_pulse !== 1'b0) begin n_err++; $display("FAIL reset_wp: got %b want 0", wrap_pulse); end
    reset = 1'b0;
    cyc   = 0;
    tick();
    n_vec++; if (an !== 2'b10) begin n_err++; $display("FAIL release_an: got %b want %b", an, 2'b10); end
    n_vec++; if (seg !== 7'h40) begin n_err++; $display("FAIL release_seg: got %h want %h", seg, 7'h40); end
  endtask

  task automatic test_display();
    count = 4'd3;
    tick();
    tick();
    align(0);
    tick();
    n_vec++; if (seg !== 7'h30) begin n_err++; $display("FAIL disp3_seg: got %h want %h", seg, 7'h30); end
    n_vec++; if (an !== 2'b10) begin n_err++; $display("FAIL disp3_an: got %b want %b", an, 2'b10); end
    count = 4'd0;
    tick();
    n_vec++; if (seg !== 7'h30) begin n_err++; $display("FAIL disp_lat1: got %h want %h", seg, 7'h30); end
    tick();
    n_vec++; if (seg !== 7'h40) begin n_err++; $display("FAIL disp_lat2: got %h want %h", seg, 7'h40); end
    align(1);
    tick();
    n_vec++; if (an !== 2'b01) begin n_err++; $display("FAIL disp_d1_an: got %b want %b", an, 2'b01); end
    n_vec++; if (seg !== 7'h40) begin n_err++; $display("FAIL disp_d1_seg: got %h want %h", seg, 7'h40); end
  endtask

  task automatic test_sweep();
    int p0;
    p0 = pulse_cnt;
    for (int i = 1; i < 16; i++) begin
      count = 4'(i);
      tick();
    end
    count = 4'd0;
    tick();
    n_vec++; if (wrap_pulse !== 1'b0) begin n_err++; $display("FAIL sweep_early: got %b want 0", wrap_pulse); end
    tick();
    n_vec++; if (wrap_pulse !== 1'b1) begin n_err++; $display("FAIL sweep_pulse: got %b want 1", wrap_pulse); end
    tick();
    n_vec++; if (wrap_pulse !== 1'b0) begin n_err++; $display("FAIL sweep_fall: got %b want 0", wrap_pulse); end
    n_vec++; if (pulse_cnt - p0 != 1) begin n_err++; $display("FAIL sweep_npulse: got %0d want 1", pulse_cnt - p0); end
    align(1);
    tick();
    n_vec++; if (an !== 2'b01) begin n_err++; $display("FAIL sweep_an: got %b want %b", an, 2'b01); end
    n_vec++; if (seg !== 7'h79) begin n_err++; $display("FAIL sweep_wrapcnt: got %h want %h", seg, 7'h79); end
  endtask

  task automatic test_multi_wrap();
    int p0;
    apply_reset(1);
    p0 = pulse_cnt;
    for (int w = 0; w < 16; w++) begin
      for (int i = 0; i < 16; i++) begin
        count = 4'(i);
        tick();
      end
    end
    count = 4'd0;
    repeat (3) tick();
    n_vec++; if (pulse_cnt - p0 != 16) begin n_err++; $display("FAIL multi_npulse: got %0d want 16", pulse_cnt - p0); end
    align(1);
    tick();
    n_vec++; if (seg !== 7'h40) begin n_err++; $display("FAIL multi_wrapcnt: got %h want %h", seg, 7'h40); end
  endtask

  task automatic test_jumps();
    int p0;
    count = 4'd15;
    tick();
    count = 4'd0;
    repeat (3) tick();
    p0 = pulse_cnt;
    count = 4'd7; repeat (2) tick();
    count = 4'd0; repeat (2) tick();
    count = 4'd5; repeat (2) tick();
    count = 4'd9; repeat (3) tick();
    n_vec++; if (pulse_cnt != p0) begin n_err++; $display("FAIL jump_pulses: got %0d want 0", pulse_cnt - p0); end
    align(1);
    tick();
    n_vec++; if (seg !== 7'h79) begin n_err++; $display("FAIL jump_wrapcnt: got %h want %h", seg, 7'h79); end
  endtask

  task automatic test_simultaneous();
    count = 4'd15;
    tick();
    while ((cyc % 8) != 5) tick();
    tick();
    count = 4'd0;
    tick();
    tick();
    n_vec++; if (wrap_pulse !== 1'b1) begin n_err++; $display("FAIL simul_pulse: got %b want 1", wrap_pulse); end
    n_vec++; if (an !== 2'b01) begin n_err++; $display("FAIL simul_an: got %b want %b", an, 2'b01); end
    n_vec++; if (seg !== 7'h79) begin n_err++; $display("FAIL simul_old: got %h want %h", seg, 7'h79); end
    tick();
    n_vec++; if (an !== 2'b10) begin n_err++; $display("FAIL simul_toggle: got %b want %b", an, 2'b10); end
    align(1);
    tick();
    n_vec++; if (seg !== 7'h24) begin n_err++; $display("FAIL simul_new: got %h want %h", seg, 7'h24); end
  endtask

  task automatic test_mid_reset();
    int p0;
    for (int i = 1; i < 16; i++) begin
      count = 4'(i);
      tick();
    end
    tick();
    reset = 1'b1;
    tick();
    n_vec++; if (seg !== 7'h7F) begin n_err++; $display("FAIL mid_seg: got %h want %h", seg, 7'h7F); end
    n_vec++; if (an !== 2'b11) begin n_err++; $display("FAIL mid_an: got %b want %b", an, 2'b11); end
    n_vec++; if (wrap_pulse !== 1'b0) begin n_err++; $display("FAIL mid_wp: got %b want 0", wrap_pulse); end
    reset = 1'b0;
    cyc   = 0;
    count = 4'd0;
    p0    = pulse_cnt;
    tick();
    n_vec++; if (wrap_pulse !== 1'b0) begin n_err++; $display("FAIL mid_wp1: got %b want 0", wrap_pulse); end
    n_vec++; if (an !== 2'b10) begin n_err++; $display("FAIL mid_an1: got %b want %b", an, 2'b10); end
    n_vec++; if (seg !== 7'h40) begin n_err++; $display("FAIL mid_seg1: got %h want %h", seg, 7'h40); end
    tick();
    n_vec++; if (wrap_pulse !== 1'b0) begin n_err++; $display("FAIL mid_wp2: got %b want 0", wrap_pulse); end
    tick();
    n_vec++; if (wrap_pulse !== 1'b0) begin n_err++; $display("FAIL mid_wp3: got %b want 0", wrap_pulse); end
    tick();
    n_vec++; if (pulse_cnt != p0) begin n_err++; $display("FAIL mid_pulses: got %0d want 0", pulse_cnt - p0); end
    align(1);
    tick();
    n_vec++; if (seg !== 7'h40) begin n_err++; $display("FAIL mid_wrapcnt: got %h want %h", seg, 7'h40); end
  endtask

  task automatic test_monitor();
    tick();
    n_vec++; if (width_viol != 0) begin n_err++; $display("FAIL mon_width: got %0d want 0", width_viol); end
    n_vec++; if (both_on != 0) begin n_err++; $display("FAIL mon_both_on: got %0d want 0", both_on); end
    n_vec++; if (period_viol != 0) begin n_err++; $display("FAIL mon_period: got %0d want 0", period_viol); end
    n_vec++; if (toggles < 10) begin n_err++; $display("FAIL mon_toggles: got %0d want >=10", toggles); end
  endtask

  initial begin
    test_reset();
    test_display();
    test_sweep();
    test_multi_wrap();
    test_jumps();
    test_simultaneous();
    test_mid_reset();
    test_monitor();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
